life_run_ctrl: RTL



---
 rtl/life_run_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/life_run_ctrl.sv
// life_run_ctrl: job sequencer for the 16x16 toroidal Life engine.
// Loads a seed, advances a programmed number of generations with pause and
// single-step, and stops early when every cell is dead. Defining
// LIFE_STABLE_DETECT_EN adds a previous-generation register so the run also
// stops on a period-1 still life.
module life_run_ctrl #(
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [255:0]     pattern,
    input  logic [GEN_W-1:0] gens,
    input  logic             pause,
    input  logic             step,
    input  logic [255:0]     eng_q,
    output logic             eng_load,
    output logic [255:0]     eng_data,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             extinct,
    output logic             stable
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [255:0]     pat_r;
    logic [GEN_W-1:0] gens_r;
    logic [GEN_W-1:0] gen_inc;
    logic             accept;
    logic             all_dead;
    logic             still;
    logic             adv;
    logic             run_adv;

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign all_dead = (eng_q == '0);
    assign adv      = !pause || step;
    assign gen_inc  = gen_count + 1'b1;
    // A reset edge must not also advance the engine: it freezes where it is.
    assign run_adv  = (state == S_RUN) && !all_dead && !still && adv && !reset;

`ifdef LIFE_STABLE_DETECT_EN
    logic [255:0] prev_q;
    logic         prev_valid;
    logic         stable_r;

    assign still  = prev_valid && (eng_q == prev_q);
    assign stable = stable_r;

    // Remember the generation we are about to leave so the next one can be compared.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            prev_valid <= 1'b0;
            stable_r   <= 1'b0;
        end else begin
            if (accept) begin
                prev_valid <= 1'b0;
                stable_r   <= 1'b0;
            end else if (run_adv) begin
                prev_q     <= eng_q;
                prev_valid <= 1'b1;
            end
            if (state == S_RUN && !all_dead && still)
                stable_r <= 1'b1;
        end
    end
`else
    assign still  = 1'b0;
    assign stable = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; extinction outranks still-life, which outranks advancing.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_LOAD;
            S_LOAD: state_nxt = (gens_r == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (all_dead || still)               state_nxt = S_DONE;
                else if (adv && gen_inc == gens_r)   state_nxt = S_DONE;
            end
            S_DONE: if (accept) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Engine drive: hold (reload own state) unless loading the seed or advancing.
    always_comb begin
        eng_load = 1'b1;
        eng_data = eng_q;
        case (state)
            S_LOAD:  eng_data = pat_r;
            S_RUN:   if (run_adv) eng_load = 1'b0;
            default: ;
        endcase
    end

    // Job registers and status flags; busy/done follow the next state so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r     <= '0;
            gens_r    <= '0;
            gen_count <= '0;
            extinct   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                pat_r     <= pattern;
                gens_r    <= gens;
                gen_count <= '0;
                extinct   <= 1'b0;
            end else if (run_adv) begin
                gen_count <= gen_inc;
            end
            if (state == S_RUN && all_dead)
                extinct <= 1'b1;
            busy <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
        end
    end

endmodule
